mac_frame_gen: RTL and testbench

- Builds one complete Ethernet II frame from header fields and a byte-array payload, then streams it as 64-bit words, one per clock.
- Frame on the wire: preamble, SFD, destination, source, EtherType, payload padded to 46 bytes, FCS.
- Sits in front of the MII/BASE-R encoder path as a traffic source for the verification environment.

---
 rtl/mac_frame_gen.sv | 196 +++++++++++++++++++
 tb/tb_mac_frame_gen.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_frame_gen.sv
// Ethernet II frame source: latches header fields and payload on a start request,
// then streams preamble, header, padded payload and FCS as 64-bit words, one per clock.
module mac_frame_gen #(
    parameter int         PAYLOAD_MAX_SIZE     = 64,
    parameter logic [7:0] PAYLOAD_CHAR_PATTERN = 8'h55,
    parameter int         PAYLOAD_LENGTH       = 8
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [47:0] i_dest_address,
    input  logic [47:0] i_src_address,
    input  logic [15:0] i_eth_type,
    input  logic [15:0] i_payload_length,
    input  logic [7:0]  i_payload [PAYLOAD_MAX_SIZE],
    output logic        o_valid,
    output logic [63:0] o_frame_out,
    output logic        o_done
);

    localparam int MIN_PAYLOAD = 46;
    localparam int MAX_PADDED  = (PAYLOAD_MAX_SIZE > MIN_PAYLOAD) ? PAYLOAD_MAX_SIZE : MIN_PAYLOAD;
    localparam int MAX_WORDS   = (26 + MAX_PADDED + 7) / 8;
    localparam int LW          = $clog2(MAX_PADDED + 1);
    localparam int WW          = $clog2(MAX_WORDS + 1);
    localparam int PIW         = (PAYLOAD_MAX_SIZE > 1) ? $clog2(PAYLOAD_MAX_SIZE) : 1;
    localparam logic [63:0] PREAMBLE_WORD = 64'hD555_5555_5555_5555;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_n;

    logic [47:0]   dest_q, src_q;
    logic [15:0]   type_q;
    logic [7:0]    payload_q [PAYLOAD_MAX_SIZE];
    logic [LW-1:0] len_q, pad_q;
    logic [WW-1:0] words_q, idx_q, idx_n;
    logic [31:0]   crc_q, crc_n, crc_word;
    logic [63:0]   frame_n, word_c;
    logic          valid_n, done_n;
    logic [LW-1:0] len_c, pad_c;
    logic [WW-1:0] words_c;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Effective, padded length and word count derived from the live inputs at latch time.
    always_comb begin
        int l;
        int p;
        if (i_payload_length == 16'd0) begin
            l = PAYLOAD_LENGTH;
        end else if (int'(i_payload_length) > PAYLOAD_MAX_SIZE) begin
            l = PAYLOAD_MAX_SIZE;
        end else begin
            l = int'(i_payload_length);
        end
        p       = (l > MIN_PAYLOAD) ? l : MIN_PAYLOAD;
        len_c   = LW'(l);
        pad_c   = LW'(p);
        words_c = WW'((26 + p + 7) / 8);
    end

    // Build word idx_q lane by lane. The CRC is advanced over data lanes in wire order,
    // so any FCS lane in the same word already sees every preceding data byte.
    always_comb begin
        int         pos;
        int         q;
        int         j;
        int         pad;
        int         len;
        logic [31:0] c;
        logic [7:0]  b;
        word_c = '0;
        c      = crc_q;
        pad    = int'(pad_q);
        len    = int'(len_q);
        for (int k = 0; k < 8; k++) begin
            pos = int'(idx_q) * 8 + k;
            q   = pos - 22;
            j   = pos - 22 - pad;
            b   = 8'h00;
            if (pos < 7) begin
                b = 8'h55;
            end else if (pos == 7) begin
                b = 8'hD5;
            end else if (pos < 14) begin
                b = 8'(dest_q >> (8 * (13 - pos)));
            end else if (pos < 20) begin
                b = 8'(src_q >> (8 * (19 - pos)));
            end else if (pos < 22) begin
                b = 8'(type_q >> (8 * (21 - pos)));
            end else if (q < pad) begin
                b = (q < len) ? payload_q[q[PIW-1:0]] : PAYLOAD_CHAR_PATTERN;
            end else if (j < 4) begin
                b = 8'(~c >> (8 * j));
            end
            if (pos >= 8 && q < pad) begin
                c = crc_byte(c, b);
            end
            word_c[8*k +: 8] = b;
        end
        crc_word = c;
    end

    always_comb begin
        state_n = state;
        valid_n = 1'b0;
        frame_n = '0;
        done_n  = 1'b0;
        idx_n   = idx_q;
        crc_n   = crc_q;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_n = SEND;
                    valid_n = 1'b1;
                    frame_n = PREAMBLE_WORD;
                    idx_n   = WW'(1);
                    crc_n   = 32'hFFFF_FFFF;
                end
            end
            SEND: begin
                if (idx_q < words_q) begin
                    valid_n = 1'b1;
                    frame_n = word_c;
                    idx_n   = idx_q + WW'(1);
                    crc_n   = crc_word;
                end else begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end
            end
            DONE: begin
                // Wait for start to drop so a held request yields one frame only.
                if (!i_start) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_valid     <= 1'b0;
            o_frame_out <= '0;
            o_done      <= 1'b0;
            idx_q       <= '0;
            crc_q       <= 32'hFFFF_FFFF;
        end else begin
            state       <= state_n;
            o_valid     <= valid_n;
            o_frame_out <= frame_n;
            o_done      <= done_n;
            idx_q       <= idx_n;
            crc_q       <= crc_n;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dest_q  <= '0;
            src_q   <= '0;
            type_q  <= '0;
            len_q   <= '0;
            pad_q   <= '0;
            words_q <= '0;
            for (int i = 0; i < PAYLOAD_MAX_SIZE; i++) begin
                payload_q[i] <= '0;
            end
        end else if (state == IDLE && i_start) begin
            dest_q  <= i_dest_address;
            src_q   <= i_src_address;
            type_q  <= i_eth_type;
            len_q   <= len_c;
            pad_q   <= pad_c;
            words_q <= words_c;
            for (int i = 0; i < PAYLOAD_MAX_SIZE; i++) begin
                payload_q[i] <= i_payload[i];
            end
        end
    end

endmodule

// File: tb/tb_mac_frame_gen.sv
// Directed bench for mac_frame_gen: table of frame requests checked word-by-word
// against a byte-level frame model with its own CRC-32, plus reset/hold sequences.
module tb_mac_frame_gen;

    logic        clk;
    logic        i_rst_n;
    logic        i_start;
    logic [47:0] i_dest_address;
    logic [47:0] i_src_address;
    logic [15:0] i_eth_type;
    logic [15:0] i_payload_length;
    logic [7:0]  payload [64];
    logic        o_valid;
    logic [63:0] o_frame_out;
    logic        o_done;

    mac_frame_gen dut (
        .clk              (clk),
        .i_rst_n          (i_rst_n),
        .i_start          (i_start),
        .i_dest_address   (i_dest_address),
        .i_src_address    (i_src_address),
        .i_eth_type       (i_eth_type),
        .i_payload_length (i_payload_length),
        .i_payload        (payload),
        .o_valid          (o_valid),
        .o_frame_out      (o_frame_out),
        .o_done           (o_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] dest;
        logic [47:0] src;
        logic [15:0] etype;
        logic [15:0] len;
        int          kind;
        int          hold;
        int          exp_words;
    } vec_t;

    vec_t        vecs [6];
    logic [63:0] exp_q [$];
    logic [63:0] cap [16];
    logic [7:0]  last_fcs;
    int          tests;
    int          failed;

    task automatic chk(input string tag, input int id, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s (case %0d): got %h, expected %h", tag, id, act, exp);
        end
    endtask

    function automatic logic [31:0] crc32(input logic [7:0] b [$], input int from);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = from; i < b.size(); i++) begin
            c = c ^ {24'h0, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic fill_payload(input int kind);
        for (int i = 0; i < 64; i++) begin
            case (kind)
                0:       payload[i] = 8'(i * 7 + 3);
                1:       payload[i] = 8'hAA;
                default: payload[i] = 8'(i * 3 + 1);
            endcase
        end
        if (kind == 0) begin
            payload[0] = 8'hBB; payload[1] = 8'hAA; payload[2] = 8'hDE; payload[3] = 8'hAD;
            payload[4] = 8'hBE; payload[5] = 8'hEF; payload[6] = 8'h12; payload[7] = 8'h34;
        end
    endtask

    // driver: frame model from the current inputs, pushed as words into exp_q
    task automatic build_expected();
        logic [7:0]  b [$];
        logic [31:0] c;
        logic [63:0] wd;
        int          l;
        int          p;
        if (i_payload_length == 16'd0) l = 8;
        else if (i_payload_length > 16'd64) l = 64;
        else l = int'(i_payload_length);
        p = (l < 46) ? 46 : l;
        repeat (7) b.push_back(8'h55);
        b.push_back(8'hD5);
        for (int i = 0; i < 6; i++) b.push_back(i_dest_address[8*(5-i) +: 8]);
        for (int i = 0; i < 6; i++) b.push_back(i_src_address[8*(5-i) +: 8]);
        b.push_back(i_eth_type[15:8]);
        b.push_back(i_eth_type[7:0]);
        for (int i = 0; i < p; i++) b.push_back((i < l) ? payload[i] : 8'h55);
        c = crc32(b, 8);
        for (int i = 0; i < 4; i++) b.push_back(c[8*i +: 8]);
        last_fcs = c[31:24];
        while (b.size() % 8 != 0) b.push_back(8'h00);
        for (int w = 0; w < b.size() / 8; w++) begin
            for (int k = 0; k < 8; k++) wd[8*k +: 8] = b[8*w + k];
            exp_q.push_back(wd);
        end
    endtask

    // driver + scoreboard: raise start for `hold` edges, then watch a fixed window
    task automatic run_frame(input int id, input int hold, input int exp_words);
        int nvalid;
        int ndone;
        int first_c;
        int last_c;
        int done_c;
        int nz_bad;
        logic [63:0] ew;
        nvalid = 0; ndone = 0; first_c = -1; last_c = -1; done_c = -1; nz_bad = 0;
        @(negedge clk);
        i_start = 1'b1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            @(negedge clk);
            if (o_valid) begin
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                if (nvalid < 16) cap[nvalid] = o_frame_out;
                if (exp_q.size() > 0) begin
                    ew = exp_q.pop_front();
                    chk("word", id, o_frame_out, ew);
                end
                nvalid++;
            end else if (o_frame_out !== 64'h0) begin
                nz_bad++;
            end
            if (o_done) begin
                ndone++;
                done_c = cyc;
            end
            if (cyc == 1) begin
                // inputs changing after the latch must not reach the frame
                i_dest_address   = ~i_dest_address;
                payload[0]       = ~payload[0];
                i_payload_length = 16'd3;
            end
            if (cyc + 1 >= hold) i_start = 1'b0;
        end
        chk("first_latency", id, 64'(first_c), 64'd0);
        chk("word_count", id, 64'(nvalid), 64'(exp_words));
        chk("no_gaps", id, 64'(last_c - first_c + 1), 64'(exp_words));
        chk("done_count", id, 64'(ndone), 64'd1);
        chk("done_after_last", id, 64'(done_c), 64'(last_c + 1));
        chk("zero_when_idle", id, 64'(nz_bad), 64'd0);
        chk("exp_left", id, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] ref_b [$];
        tests = 0;
        failed = 0;

        vecs[0] = '{48'hFFFF_FFFF_FFFF, 48'h1122_3344_5566, 16'h0800, 16'd8,   0, 1,  9};
        vecs[1] = '{48'hFFFF_FFFF_FFFF, 48'h1122_3344_5566, 16'h0800, 16'd8,   0, 50, 9};
        vecs[2] = '{48'hFFFF_FFFF_FFFF, 48'h1122_3344_5566, 16'h0800, 16'd0,   0, 1,  9};
        vecs[3] = '{48'h0200_0000_0001, 48'h0A0B_0C0D_0E0F, 16'h86DD, 16'd46,  1, 1,  9};
        vecs[4] = '{48'h0123_4567_89AB, 48'hCDEF_0011_2233, 16'h0806, 16'd47,  2, 1,  10};
        vecs[5] = '{48'hA1A2_A3A4_A5A6, 48'hB1B2_B3B4_B5B6, 16'h88B5, 16'd100, 2, 1,  12};

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_dest_address = '0;
        i_src_address = '0;
        i_eth_type = '0;
        i_payload_length = '0;
        fill_payload(0);
        repeat (2) @(negedge clk);
        chk("reset_valid", 0, 64'(o_valid), 64'd0);
        chk("reset_frame", 0, o_frame_out, 64'd0);
        chk("reset_done", 0, 64'(o_done), 64'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_valid", 0, 64'(o_valid), 64'd0);

        // model sanity: CRC-32 of "123456789"
        for (int i = 0; i < 9; i++) ref_b.push_back(8'(8'h31 + i));
        chk("crc_model", 0, 64'(crc32(ref_b, 0)), 64'hCBF4_3926);

        for (int v = 0; v < 6; v++) begin
            i_dest_address   = vecs[v].dest;
            i_src_address    = vecs[v].src;
            i_eth_type       = vecs[v].etype;
            i_payload_length = vecs[v].len;
            fill_payload(vecs[v].kind);
            build_expected();
            run_frame(v, vecs[v].hold, vecs[v].exp_words);
            if (v == 0) begin
                chk("w0_preamble", v, cap[0], 64'hD555_5555_5555_5555);
                chk("w1_dest_src", v, cap[1], 64'h2211_FFFF_FFFF_FFFF);
                chk("w2_src_type", v, cap[2], 64'hAABB_0008_6655_4433);
                chk("w3_payload", v, cap[3], 64'h5555_3412_EFBE_ADDE);
            end
            if (v == 4) begin
                chk("last_word_tail", v, cap[9], {56'h0, last_fcs});
            end
        end

        // reset in the middle of SEND, then a clean frame
        i_dest_address   = 48'h0055_AA55_AA55;
        i_src_address    = 48'h1020_3040_5060;
        i_eth_type       = 16'h0800;
        i_payload_length = 16'd20;
        fill_payload(2);
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_send_valid", 6, 64'(o_valid), 64'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 6, 64'(o_valid), 64'd0);
        chk("async_rst_frame", 6, o_frame_out, 64'd0);
        chk("async_rst_done", 6, 64'(o_done), 64'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 6, 64'(o_valid), 64'd0);
        fill_payload(2);
        i_dest_address   = 48'h0055_AA55_AA55;
        i_payload_length = 16'd20;
        build_expected();
        run_frame(6, 1, 9);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
